// File: rtl/riscv_pkg.sv
// Shared RV32I constants: decoder type codes, opcodes, funct3/funct7 fields.
// Latency: n/a (constants only).
// Backpressure: n/a.
package riscv_pkg;

  // Type codes, numbered exactly as the decode stage emits them.
  localparam logic [8:0] T_LUI   = 9'd6;
  localparam logic [8:0] T_AUIPC = 9'd7;
  localparam logic [8:0] T_JAL   = 9'd8;
  localparam logic [8:0] T_JALR  = 9'd9;
  localparam logic [8:0] T_BEQ   = 9'd10;
  localparam logic [8:0] T_BNE   = 9'd11;
  localparam logic [8:0] T_BLT   = 9'd12;
  localparam logic [8:0] T_BGE   = 9'd13;
  localparam logic [8:0] T_BLTU  = 9'd14;
  localparam logic [8:0] T_BGEU  = 9'd15;
  localparam logic [8:0] T_ADDI  = 9'd16;
  localparam logic [8:0] T_SLTI  = 9'd17;
  localparam logic [8:0] T_SLTIU = 9'd18;
  localparam logic [8:0] T_XORI  = 9'd19;
  localparam logic [8:0] T_ORI   = 9'd20;
  localparam logic [8:0] T_ANDI  = 9'd21;
  localparam logic [8:0] T_SLLI  = 9'd22;
  localparam logic [8:0] T_SRLI  = 9'd23;
  localparam logic [8:0] T_SRAI  = 9'd24;
  localparam logic [8:0] T_ADD   = 9'd25;
  localparam logic [8:0] T_SUB   = 9'd26;
  localparam logic [8:0] T_SLL   = 9'd27;
  localparam logic [8:0] T_SLT   = 9'd28;
  localparam logic [8:0] T_SLTU  = 9'd29;
  localparam logic [8:0] T_XOR   = 9'd30;
  localparam logic [8:0] T_SRL   = 9'd31;
  localparam logic [8:0] T_SRA   = 9'd32;
  localparam logic [8:0] T_OR    = 9'd33;
  localparam logic [8:0] T_AND   = 9'd34;
  localparam logic [8:0] T_LOAD  = 9'd35;

  // Major opcodes.
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // funct3 values (shared between register and immediate ALU forms where equal).
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;  // SUB / SRA / SRAI

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/inst_out_fifo.sv
// Two-entry FIFO with registered head; ports: clk_i, rst_i, push_*_i/o, pop_*_i/o.
// Latency: a word pushed at edge N is visible on pop_dat_o after edge N.
// Backpressure: push_rdy_o depends only on registered occupancy; push and pop may coincide.
module inst_out_fifo #(
  parameter int          DW      = 64,
  parameter logic [DW-1:0] RST_DAT = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_vld_i,
  output logic          push_rdy_o,
  input  logic [DW-1:0] push_dat_i,
  output logic          pop_vld_o,
  input  logic          pop_rdy_i,
  output logic [DW-1:0] pop_dat_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          push, pop;

  assign push_rdy_o = (cnt_q != 2'd2);
  assign pop_vld_o  = (cnt_q != 2'd0);
  assign pop_dat_o  = mem_q[rd_ptr_q];

  assign push = push_vld_i & push_rdy_o;
  assign pop  = pop_vld_o & pop_rdy_i;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= RST_DAT;
      mem_q[1] <= RST_DAT;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Packs decoded RV32I fields into instruction words tagged with a byte address.
// Latency: 1 cycle from accept to out_valid. Backpressure: 2-entry buffer, in_ready = occupancy < 2.
// Ports: clk/reset; in_valid/in_ready + instr_type/rd/rs1/rs2/imm; out_valid/out_ready + out_inst/out_addr; illegal, err_cnt.
module inst_encoder
  import riscv_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               REG_WIDTH = 5,
  parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int               ERR_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8:0]           instr_type,
  input  logic [REG_WIDTH-1:0] rd,
  input  logic [REG_WIDTH-1:0] rs1,
  input  logic [REG_WIDTH-1:0] rs2,
  input  logic [WIDTH-1:0]     imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_inst,
  output logic [WIDTH-1:0]     out_addr,
  output logic                 illegal,
  output logic [ERR_W-1:0]     err_cnt
);

  logic [WIDTH-1:0] enc_inst;
  logic             enc_legal;
  logic             accept;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             illegal_q, illegal_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    enc_inst  = NOP;
    enc_legal = 1'b1;
    case (instr_type)
      T_LUI:   enc_inst = {imm[31:12], rd, OP_LUI};
      T_AUIPC: enc_inst = {imm[31:12], rd, OP_AUIPC};
      T_JAL:   enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      T_JALR:  enc_inst = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      // Branch offsets are even, so imm[0] has no slot in the word.
      T_BEQ:   enc_inst = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,  imm[4:1], imm[11], OP_BRANCH};
      T_BNE:   enc_inst = {imm[12], imm[10:5], rs2, rs1, F3_BNE,  imm[4:1], imm[11], OP_BRANCH};
      T_BLT:   enc_inst = {imm[12], imm[10:5], rs2, rs1, F3_BLT,  imm[4:1], imm[11], OP_BRANCH};
      T_BGE:   enc_inst = {imm[12], imm[10:5], rs2, rs1, F3_BGE,  imm[4:1], imm[11], OP_BRANCH};
      T_BLTU:  enc_inst = {imm[12], imm[10:5], rs2, rs1, F3_BLTU, imm[4:1], imm[11], OP_BRANCH};
      T_BGEU:  enc_inst = {imm[12], imm[10:5], rs2, rs1, F3_BGEU, imm[4:1], imm[11], OP_BRANCH};
      T_ADDI:  enc_inst = {imm[11:0], rs1, F3_ADD,  rd, OP_IMM};
      T_SLTI:  enc_inst = {imm[11:0], rs1, F3_SLT,  rd, OP_IMM};
      T_SLTIU: enc_inst = {imm[11:0], rs1, F3_SLTU, rd, OP_IMM};
      T_XORI:  enc_inst = {imm[11:0], rs1, F3_XOR,  rd, OP_IMM};
      T_ORI:   enc_inst = {imm[11:0], rs1, F3_OR,   rd, OP_IMM};
      T_ANDI:  enc_inst = {imm[11:0], rs1, F3_AND,  rd, OP_IMM};
      // Shift-immediates take only the 5-bit shamt; funct7 selects arithmetic.
      T_SLLI:  enc_inst = {F7_ZERO, imm[4:0], rs1, F3_SLL, rd, OP_IMM};
      T_SRLI:  enc_inst = {F7_ZERO, imm[4:0], rs1, F3_SR,  rd, OP_IMM};
      T_SRAI:  enc_inst = {F7_ALT,  imm[4:0], rs1, F3_SR,  rd, OP_IMM};
      T_ADD:   enc_inst = {F7_ZERO, rs2, rs1, F3_ADD,  rd, OP_REG};
      T_SUB:   enc_inst = {F7_ALT,  rs2, rs1, F3_ADD,  rd, OP_REG};
      T_SLL:   enc_inst = {F7_ZERO, rs2, rs1, F3_SLL,  rd, OP_REG};
      T_SLT:   enc_inst = {F7_ZERO, rs2, rs1, F3_SLT,  rd, OP_REG};
      T_SLTU:  enc_inst = {F7_ZERO, rs2, rs1, F3_SLTU, rd, OP_REG};
      T_XOR:   enc_inst = {F7_ZERO, rs2, rs1, F3_XOR,  rd, OP_REG};
      T_SRL:   enc_inst = {F7_ZERO, rs2, rs1, F3_SR,   rd, OP_REG};
      T_SRA:   enc_inst = {F7_ALT,  rs2, rs1, F3_SR,   rd, OP_REG};
      T_OR:    enc_inst = {F7_ZERO, rs2, rs1, F3_OR,   rd, OP_REG};
      T_AND:   enc_inst = {F7_ZERO, rs2, rs1, F3_AND,  rd, OP_REG};
      T_LOAD:  enc_inst = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
      default: enc_legal = 1'b0;
    endcase
  end

  // in_ready comes straight from the FIFO's registered occupancy, so an
  // illegal request is consumed under the same condition as a legal one.
  assign accept = in_valid & in_ready;

  inst_out_fifo #(
    .DW      (2 * WIDTH),
    .RST_DAT ({{WIDTH{1'b0}}, BASE_ADDR})
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (reset),
    .push_vld_i (in_valid & enc_legal),
    .push_rdy_o (in_ready),
    .push_dat_i ({enc_inst, addr_q}),
    .pop_vld_o  (out_valid),
    .pop_rdy_i  (out_ready),
    .pop_dat_o  ({out_inst, out_addr})
  );

  always_comb begin
    addr_d    = addr_q;
    illegal_d = 1'b0;
    err_cnt_d = err_cnt_q;
    if (accept && enc_legal) begin
      addr_d = addr_q + WIDTH'(4);
    end
    if (accept && !enc_legal) begin
      illegal_d = 1'b1;
      if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= BASE_ADDR;
      illegal_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      addr_q    <= addr_d;
      illegal_q <= illegal_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign illegal = illegal_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed requests push expected words, a
// negedge monitor pops and compares every transfer the DUT presents.
module tb_inst_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  instr_type = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst, out_addr;
  logic        illegal;
  logic [7:0]  err_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_addr = BASE;

  inst_encoder #(
    .WIDTH(32), .REG_WIDTH(5), .BASE_ADDR(BASE), .ERR_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr_type(instr_type), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .illegal(illegal), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next posedge whenever valid & ready hold now.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %h @ %h, expected none", out_inst, out_addr);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("sb_inst", out_inst, e[63:32]);
        chk("sb_addr", out_addr, e[31:0]);
      end
    end
  end

  // Offers one request and returns #1 after the edge that accepted it.
  task automatic send(input logic [8:0] t, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im,
                      input logic [31:0] exp_inst, input bit legal);
    bit done;
    done = 1'b0;
    instr_type = t; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (legal) begin
          sb.push_back({exp_inst, exp_addr});
          exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected acceptance");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    exp_addr = BASE;
    @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_addr", out_addr, BASE);
    reset = 1'b0;
  endtask

  task automatic drain_check(input string name);
    repeat (4) @(posedge clk);
    #1;
    chk(name, sb.size(), 32'd0);
  endtask

  initial begin
    // Reset values.
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Single ADDI: one-cycle latency, first word at BASE.
    send(9'd16, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b1);
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_inst", out_inst, 32'h0050_0093);
    chk("addi_addr", out_addr, BASE);

    // Back-to-back R-type, then each format.
    send(9'd25, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b1);
    send(9'd26, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b1);
    send(9'd10, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463, 1'b1);
    send(9'd8,  5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFFDF_F0EF, 1'b1);
    send(9'd6,  5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b1);
    send(9'd24, 5'd2, 5'd3, 5'd0, 32'h0000_07E5, 32'h4051_D113, 1'b1);
    send(9'd35, 5'd4, 5'd2, 5'd0, 32'hFFFF_FFF8, 32'hFF81_2203, 1'b1);
    send(9'd9,  5'd1, 5'd5, 5'd0, 32'h0000_0010, 32'h0102_80E7, 1'b1);
    send(9'd7,  5'd10, 5'd0, 5'd0, 32'hABCD_E123, 32'hABCD_E517, 1'b1);
    send(9'd11, 5'd0, 5'd3, 5'd4, 32'hFFFF_FFF0, 32'hFE41_98E3, 1'b1);
    drain_check("formats_drained");

    // Backpressure: two words fill the buffer, third waits, output holds.
    do_reset();
    out_ready = 1'b0;
    send(9'd16, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b1);
    send(9'd25, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b1);
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    fork
      send(9'd6, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b1);
      begin
        for (int k = 0; k < 3; k++) begin
          @(posedge clk);
          #1;
          chk("bp_hold_inst", out_inst, 32'h0050_0093);
          chk("bp_hold_addr", out_addr, BASE);
          chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
      end
    join
    drain_check("bp_drained");
    chk("bp_next_addr", exp_addr, BASE + 32'd12);

    // Illegal type: no word, one-cycle pulse, counter moves, address does not.
    do_reset();
    send(9'h1FF, 5'd1, 5'd1, 5'd1, 32'd0, 32'd0, 1'b0);
    chk("ill_pulse", {31'd0, illegal}, 32'd1);
    chk("ill_err_cnt", {24'd0, err_cnt}, 32'd1);
    chk("ill_no_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("ill_pulse_end", {31'd0, illegal}, 32'd0);
    send(9'd16, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b1);
    chk("ill_next_addr", out_addr, BASE);
    for (int k = 0; k < 299; k++) send(9'h1FF, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("ill_err_sat", {24'd0, err_cnt}, 32'd255);
    drain_check("ill_drained");

    // Reset with two words queued.
    out_ready = 1'b0;
    send(9'd25, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b1);
    send(9'd26, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b1);
    chk("q2_valid", {31'd0, out_valid}, 32'd1);
    do_reset();
    chk("q2_err_cnt", {24'd0, err_cnt}, 32'd0);
    out_ready = 1'b1;
    send(9'd33, 5'd7, 5'd8, 5'd9, 32'd0, 32'h0094_63B3, 1'b1);
    chk("q2_next_addr", out_addr, BASE);
    drain_check("q2_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
